// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the sync/blank bundle type.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  // Bundle that travels through the alignment delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-qualified shift register that keeps sync/blank aligned with the
// registered RGB of the downstream colour stage. DEPTH = 0 is a wire.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int    DEPTH   = 1,
  parameter sync_t RST_VAL = '0
) (
  input  logic  iCLK,
  input  logic  iRST_N,
  input  logic  iEn,
  input  sync_t iSync,
  output sync_t oSync
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{iCLK, iRST_N, iEn};
    assign oSync      = iSync;
  end else begin : g_pipe
    sync_t [DEPTH-1:0] pipe;

    // Shift on pixel enable; reset flushes every stage to the idle vector.
    always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
        pipe <= {DEPTH{RST_VAL}};
      end else if (iEn) begin
        pipe[0] <= iSync;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign oSync = pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: x/y counters, active flag, line/frame pulses, and
// sync/blank delayed to match the downstream colour pipeline.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int PIPE_DELAY = 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iPix_En,
  output logic [CNT_W-1:0] oVga_x,
  output logic [CNT_W-1:0] oVga_y,
  output logic             oActive,
  output logic             oLine_Start,
  output logic             oFrame_Start,
  output logic             oH_SYNC,
  output logic             oV_SYNC,
  output logic             oBLANK_N
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] X_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic  HS_ON     = (H_POL != 0);
  localparam logic  VS_ON     = (V_POL != 0);
  localparam sync_t SYNC_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, blank_n: 1'b0};

  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             x_wrap, act_nxt;
  sync_t            sync_nxt, sync_q, sync_d;

  // Next raster position and its decode; registering the decode alongside
  // the counters keeps every output referring to the same pixel.
  always_comb begin
    x_wrap = (oVga_x == X_LAST);
    x_nxt  = x_wrap ? '0 : oVga_x + 1'b1;
    y_nxt  = oVga_y;
    if (x_wrap) y_nxt = (oVga_y == Y_LAST) ? '0 : oVga_y + 1'b1;
    act_nxt          = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    sync_nxt.hs      = (x_nxt >= HS_B && x_nxt <= HS_E) ? HS_ON : ~HS_ON;
    sync_nxt.vs      = (y_nxt >= VS_B && y_nxt <= VS_E) ? VS_ON : ~VS_ON;
    sync_nxt.blank_n = act_nxt;
  end

  // Counters and undelayed decode; reset parks at the last blanking pixel.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVga_x  <= X_LAST;
      oVga_y  <= Y_LAST;
      oActive <= 1'b0;
      sync_q  <= SYNC_IDLE;
    end else if (iPix_En) begin
      oVga_x  <= x_nxt;
      oVga_y  <= y_nxt;
      oActive <= act_nxt;
      sync_q  <= sync_nxt;
    end
  end

  // Start pulses last one iCLK: set on an enabled step into x=0, cleared
  // on the next edge whether or not the pixel enable is high.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oLine_Start  <= 1'b0;
      oFrame_Start <= 1'b0;
    end else begin
      oLine_Start  <= iPix_En && (x_nxt == '0);
      oFrame_Start <= iPix_En && (x_nxt == '0) && (y_nxt == '0);
    end
  end

  vga_sync_delay #(
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_dly (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iEn    (iPix_En),
    .iSync  (sync_q),
    .oSync  (sync_d)
  );

  assign oH_SYNC  = sync_d.hs;
  assign oV_SYNC  = sync_d.vs;
  assign oBLANK_N = sync_d.blank_n;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing at PIPE_DELAY 1/0/4, plus a tiny raster
// (15x11, active-high hsync) so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [10:0] x1, y1, x0, y0, x4, y4, xs, ys;
  logic a1, ls1, fs1, hs1, vs1, bn1;
  logic a0, ls0, fs0, hs0, vs0, bn0;
  logic a4, ls4, fs4, hs4, vs4, bn4;
  logic as_, lss, fss, hss, vss, bns;

  vga_sync_gen #(.PIPE_DELAY(1)) d1 (
    .iCLK(clk), .iRST_N(rst_n), .iPix_En(en), .oVga_x(x1), .oVga_y(y1),
    .oActive(a1), .oLine_Start(ls1), .oFrame_Start(fs1), .oH_SYNC(hs1),
    .oV_SYNC(vs1), .oBLANK_N(bn1));

  vga_sync_gen #(.PIPE_DELAY(0)) d0 (
    .iCLK(clk), .iRST_N(rst_n), .iPix_En(en), .oVga_x(x0), .oVga_y(y0),
    .oActive(a0), .oLine_Start(ls0), .oFrame_Start(fs0), .oH_SYNC(hs0),
    .oV_SYNC(vs0), .oBLANK_N(bn0));

  vga_sync_gen #(.PIPE_DELAY(4)) d4 (
    .iCLK(clk), .iRST_N(rst_n), .iPix_En(en), .oVga_x(x4), .oVga_y(y4),
    .oActive(a4), .oLine_Start(ls4), .oFrame_Start(fs4), .oH_SYNC(hs4),
    .oV_SYNC(vs4), .oBLANK_N(bn4));

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1), .V_POL(0), .PIPE_DELAY(1)
  ) ds (
    .iCLK(clk), .iRST_N(rst_n), .iPix_En(en), .oVga_x(xs), .oVga_y(ys),
    .oActive(as_), .oLine_Start(lss), .oFrame_Start(fss), .oH_SYNC(hss),
    .oV_SYNC(vss), .oBLANK_N(bns));

  // One iCLK: drive enable at the falling edge, sample at the next one.
  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (x1 !== 11'd799) begin failures++; $display("FAIL rst_x got %0d want 799", x1); end
    checks++; if (y1 !== 11'd524) begin failures++; $display("FAIL rst_y got %0d want 524", y1); end
    checks++; if ({a1, ls1, fs1} !== 3'b000) begin failures++; $display("FAIL rst_flags got %b want 000", {a1, ls1, fs1}); end
    checks++; if ({hs1, vs1, bn1} !== 3'b110) begin failures++; $display("FAIL rst_sync got %b want 110", {hs1, vs1, bn1}); end
    checks++; if ({hs4, vs4, bn4} !== 3'b110) begin failures++; $display("FAIL rst_sync_d4 got %b want 110", {hs4, vs4, bn4}); end
    checks++; if ({hss, vss} !== 2'b01) begin failures++; $display("FAIL rst_pol_small got %b want 01", {hss, vss}); end
    rst_n = 1'b1;
    step(1'b1);
    checks++; if ({x1, y1} !== 22'd0) begin failures++; $display("FAIL first_xy got %0d,%0d want 0,0", x1, y1); end
    checks++; if ({a1, ls1, fs1} !== 3'b111) begin failures++; $display("FAIL first_flags got %b want 111", {a1, ls1, fs1}); end
    checks++; if ({bn1, bn0} !== 2'b01) begin failures++; $display("FAIL first_blank got d1=%b d0=%b want 0 1", bn1, bn0); end
    step(1'b1);
    checks++; if ({ls1, fs1} !== 2'b00) begin failures++; $display("FAIL pulse_width got %b want 00", {ls1, fs1}); end
    checks++; if (x1 !== 11'd1 || bn1 !== 1'b1) begin failures++; $display("FAIL second_px got x=%0d bn=%b want 1 1", x1, bn1); end
    step(1'b1);
    step(1'b1);
    checks++; if (bn4 !== 1'b0) begin failures++; $display("FAIL d4_blank_x3 got %b want 0", bn4); end
    step(1'b1);
    checks++; if (x4 !== 11'd4 || bn4 !== 1'b1) begin failures++; $display("FAIL d4_blank_x4 got x=%0d bn=%b want 4 1", x4, bn4); end
  endtask

  // Continues from x=4 on line 0 through to the start of line 1.
  task automatic test_line();
    int   act_fall = -1, f1 = -1, f0 = -1, f4 = -1;
    int   lo1 = 0, lo0 = 0, lo4 = 0, vlo = 0, lsc = 0;
    logic prev_a = 1'b1;
    for (int n = 0; n < 796; n++) begin
      step(1'b1);
      if (prev_a && !a1 && act_fall < 0) act_fall = int'(x1);
      prev_a = a1;
      if (!hs1) begin lo1++; if (f1 < 0) f1 = int'(x1); end
      if (!hs0) begin lo0++; if (f0 < 0) f0 = int'(x0); end
      if (!hs4) begin lo4++; if (f4 < 0) f4 = int'(x4); end
      if (!vs1) vlo++;
      if (ls1) lsc++;
    end
    checks++; if (act_fall != 640) begin failures++; $display("FAIL active_fall_x got %0d want 640", act_fall); end
    checks++; if (f1 != 657) begin failures++; $display("FAIL hs_fall_d1 got %0d want 657", f1); end
    checks++; if (f0 != 656) begin failures++; $display("FAIL hs_fall_d0 got %0d want 656", f0); end
    checks++; if (f4 != 660) begin failures++; $display("FAIL hs_fall_d4 got %0d want 660", f4); end
    checks++; if (lo1 != 96) begin failures++; $display("FAIL hs_width_d1 got %0d want 96", lo1); end
    checks++; if (lo0 != 96) begin failures++; $display("FAIL hs_width_d0 got %0d want 96", lo0); end
    checks++; if (lo4 != 96) begin failures++; $display("FAIL hs_width_d4 got %0d want 96", lo4); end
    checks++; if (vlo != 0) begin failures++; $display("FAIL vs_line0 got %0d low want 0", vlo); end
    checks++; if (lsc != 1) begin failures++; $display("FAIL line_pulses got %0d want 1", lsc); end
    checks++; if (x1 !== 11'd0 || y1 !== 11'd1) begin failures++; $display("FAIL line_wrap got %0d,%0d want 0,1", x1, y1); end
    checks++; if ({ls1, fs1} !== 2'b10) begin failures++; $display("FAIL line_wrap_pulse got %b want 10", {ls1, fs1}); end
  endtask

  // Small raster: 15 x 11 = 165 enabled cycles per frame.
  task automatic test_frame();
    int fsc = 0, lsc = 0, hhi = 0, vlo = 0, act = 0;
    int fs_first = -1, fs_last = -1, vy = -1, vx = -1;
    apply_reset();
    for (int k = 1; k <= 166; k++) begin
      step(1'b1);
      if (fss) begin fsc++; if (fs_first < 0) fs_first = k; fs_last = k; end
      if (lss) lsc++;
      if (hss) hhi++;
      if (!vss) begin vlo++; if (vy < 0) begin vy = int'(ys); vx = int'(xs); end end
      if (as_ && k <= 165) act++;
      if (k == 165) begin
        checks++; if (xs !== 11'd14 || ys !== 11'd10) begin failures++; $display("FAIL frame_last got %0d,%0d want 14,10", xs, ys); end
      end
    end
    checks++; if (xs !== 11'd0 || ys !== 11'd0 || fss !== 1'b1) begin failures++; $display("FAIL frame_wrap got %0d,%0d fs=%b want 0,0 1", xs, ys, fss); end
    checks++; if (fsc != 2 || fs_last - fs_first != 165) begin failures++; $display("FAIL frame_period got n=%0d d=%0d want 2 165", fsc, fs_last - fs_first); end
    checks++; if (lsc != 12) begin failures++; $display("FAIL frame_lines got %0d want 12", lsc); end
    checks++; if (hhi != 33) begin failures++; $display("FAIL frame_hs_hi got %0d want 33", hhi); end
    checks++; if (vlo != 30) begin failures++; $display("FAIL frame_vs_lo got %0d want 30", vlo); end
    checks++; if (vy != 7 || vx != 1) begin failures++; $display("FAIL vs_start got %0d,%0d want 1,7", vx, vy); end
    checks++; if (act != 48) begin failures++; $display("FAIL frame_active got %0d want 48", act); end
  endtask

  // Enable alternates 1/0: 1602 iCLKs = 801 enabled steps.
  task automatic test_pix_en();
    int lsc = 0, hlo = 0;
    apply_reset();
    for (int i = 0; i < 1602; i++) begin
      step((i % 2) == 0);
      if (ls1) lsc++;
      if (!hs1) hlo++;
      if (i == 0) begin
        checks++; if (x1 !== 11'd0 || ls1 !== 1'b1) begin failures++; $display("FAIL en_first got x=%0d ls=%b want 0 1", x1, ls1); end
      end
      if (i == 1) begin
        checks++; if (x1 !== 11'd0 || {ls1, fs1} !== 2'b00) begin failures++; $display("FAIL en_hold got x=%0d p=%b want 0 00", x1, {ls1, fs1}); end
      end
    end
    checks++; if (lsc != 2) begin failures++; $display("FAIL en_ls_cycles got %0d want 2", lsc); end
    checks++; if (hlo != 192) begin failures++; $display("FAIL en_hs_iclk got %0d want 192", hlo); end
    checks++; if (x1 !== 11'd0 || y1 !== 11'd1 || ls1 !== 1'b0) begin failures++; $display("FAIL en_end got %0d,%0d ls=%b want 0,1 0", x1, y1, ls1); end
  endtask

  // Reset asserted while hsync is active in every delay line.
  task automatic test_mid_reset();
    int lo = 0;
    apply_reset();
    repeat (700) step(1'b1);
    checks++; if (x1 !== 11'd699 || {hs1, hs4} !== 2'b00) begin failures++; $display("FAIL pre_reset got x=%0d hs=%b want 699 00", x1, {hs1, hs4}); end
    rst_n = 1'b0;
    #1;
    checks++; if (x1 !== 11'd799 || y1 !== 11'd524) begin failures++; $display("FAIL mid_rst_xy got %0d,%0d want 799,524", x1, y1); end
    checks++; if ({hs1, hs4, vs1, bn1, a1} !== 5'b11100) begin failures++; $display("FAIL mid_rst_sync got %b want 11100", {hs1, hs4, vs1, bn1, a1}); end
    checks++; if (xs !== 11'd14 || ys !== 11'd10 || hss !== 1'b0) begin failures++; $display("FAIL mid_rst_small got %0d,%0d hs=%b want 14,10 0", xs, ys, hss); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step(1'b1);
      if (!hs1 || !hs4) lo++;
    end
    checks++; if (lo != 0) begin failures++; $display("FAIL restart_partial_sync got %0d want 0", lo); end
    checks++; if (x1 !== 11'd5 || y1 !== 11'd0) begin failures++; $display("FAIL restart_xy got %0d,%0d want 5,0", x1, y1); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_pix_en();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA raster timing: horizontal and vertical counters, pixel coordinates, active-video flag, line and frame start pulses, and HSYNC/VSYNC/BLANK_N. It is the coordinate source for the overlay/colour stage, which consumes the coordinates and returns registered RGB. Sync and blank are delayed by a parameterised number of pixel cycles so they stay aligned with that stage's output.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16; H_SYNC, 96; H_BP, 48, horizontal porch/sync widths (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10; V_SYNC, 2; V_BP, 33, vertical porch/sync widths (V_TOTAL = 525)
- H_POL, 0; V_POL, 0, asserted sync level (0 = active-low)
- PIPE_DELAY, 1, pixel-cycle delay on sync/blank relative to coordinates (legal 0..4)
- iCLK  in  1  system clock; the only clock
- iRST_N  in  1  reset, asynchronous, active-low
- iPix_En  in  1  pixel-clock enable; tie high when iCLK is the 25 MHz pixel clock
- oVga_x  out  11  horizontal counter, 0..H_TOTAL-1
- oVga_y  out  11  vertical counter, 0..V_TOTAL-1
- oActive  out  1  high when oVga_x < H_ACTIVE and oVga_y < V_ACTIVE
- oLine_Start  out  1  one-iCLK pulse when oVga_x becomes 0
- oFrame_Start  out  1  one-iCLK pulse when (oVga_x, oVga_y) becomes (0, 0)
- oH_SYNC  out  1  horizontal sync, delayed PIPE_DELAY pixel cycles
- oV_SYNC  out  1  vertical sync, delayed PIPE_DELAY pixel cycles
- oBLANK_N  out  1  delayed copy of oActive (DAC blank, active-low)

## Operation
- Counters reset to the last raster position, (H_TOTAL-1, V_TOTAL-1) = (799, 524), which is in blanking.
- Each iCLK edge with iPix_En = 1 advances the counters:
  - x: x+1; wraps to 0 at H_TOTAL-1.
  - y: advances only when x wraps; y+1, wrapping to 0 at V_TOTAL-1.
- iPix_En = 0: all state and outputs hold, except that pulses clear.
- Decode from the next counter values, registered together with the counters so all outputs are coherent:
  - oActive: x < 640 and y < 480.
  - Raw hsync asserted for x in [656, 751].
  - Raw vsync asserted for y in [490, 491], over entire lines.
- Sync and blank pass through a PIPE_DELAY-deep shift register:
  - The register advances only on iPix_En.
  - With PIPE_DELAY = 0 they are coincident with the coordinates.
- oLine_Start and oFrame_Start:
  - Set on the enabled edge that enters x = 0, or (0, 0) for oFrame_Start.
  - Cleared on the next iCLK edge regardless of iPix_En, so each lasts exactly one iCLK cycle.
  - oLine_Start fires on every line, including blanking lines.
- Arithmetic: all counters 11-bit unsigned. Comparisons use constants derived from the parameters, so there is no overflow.

## Timing
- Reset values (asserted immediately, asynchronously):
  - oVga_x = 799, oVga_y = 524, oActive = 0, oLine_Start = 0, oFrame_Start = 0.
  - oH_SYNC = oV_SYNC = inactive level (1 for default polarity), oBLANK_N = 0.
  - All delay-line stages hold these inactive values.
- First enabled edge after reset release gives (0, 0), oActive = 1, oFrame_Start = 1, oLine_Start = 1.
- Coordinate latency: 0 cycles relative to the counter register.
- Sync/blank lag the coordinates by exactly PIPE_DELAY enabled cycles. With the default PIPE_DELAY = 1, oH_SYNC falls one pixel after oVga_x = 656.
- Frame period: 800 × 525 = 420000 enabled cycles. Line period: 800 enabled cycles.
- Reset mid-frame: everything returns to the reset values within the same cycle, including delay-line contents. Restart is clean at (0, 0), with no partial sync pulse.

## Structure
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants;
  - the derived H_TOTAL, V_TOTAL, H_SYNC_START/END and V_SYNC_START/END;
  - the counter width (11).
- Sub-module vga_sync_delay: a parameterised-depth, enable-qualified shift register for {hsync, vsync, blank_n}, with reset to the inactive vector and a pass-through when depth is 0.
- Top level holds the counters, the next-state decode, and the pulse logic.

## Test plan
- Reset held, then released with iPix_En = 1 -> outputs at reset values; first edge gives (0, 0), oActive = 1, both start pulses = 1 for one cycle.
- Run one line -> at x = 640 oActive falls. oH_SYNC is low for exactly 96 enabled cycles, starting 1 cycle after x = 656 (PIPE_DELAY = 1). After x = 799 comes x = 0, y = 1, with oLine_Start pulsing.
- Run a full frame -> oV_SYNC is low for lines 490–491 only. At (799, 524) the next step is (0, 0) with oFrame_Start. Total count is 420000 cycles.
- iPix_En toggling 1/0 -> counters advance every other iCLK. Pulses last one iCLK. Sync width is still 96 enabled cycles.
- Assert iRST_N low at (300, 200) mid-line -> immediately x = 799, y = 524, sync inactive, delay line flushed. Release gives a clean (0, 0) start.
- PIPE_DELAY = 0 and 4 -> oH_SYNC edges land at x = 656 and at x = 656 + 4 respectively.
